// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory bus arbiter.
// Pure declarations; no logic, no latency.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int ARB_WAIT_W  = 8;

    typedef enum logic {
        ST_CORE  = 1'b0,
        ST_FORCE = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } arb_owner_e;

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// Core, host and RAM-side signals of the data-memory arbiter.
// slave = arbiter side, master = pipeline/host/memory environment.
interface dmem_bus_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_W,
    parameter int DATA_WIDTH = DMEM_DATA_W
) ();

    logic                  core_read_i;
    logic                  core_write_i;
    logic [ADDR_WIDTH-1:0] core_addr_i;
    logic [DATA_WIDTH-1:0] core_wdata_i;
    logic [DATA_WIDTH-1:0] core_rdata_o;
    logic                  core_stall_o;

    logic                  host_req_i;
    logic                  host_we_i;
    logic [ADDR_WIDTH-1:0] host_addr_i;
    logic [DATA_WIDTH-1:0] host_wdata_i;
    logic                  host_gnt_o;
    logic [DATA_WIDTH-1:0] host_rdata_o;
    logic                  host_valid_o;

    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  core_read_i, core_write_i, core_addr_i, core_wdata_i,
        output core_rdata_o, core_stall_o,
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
        output host_gnt_o, host_rdata_o, host_valid_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output core_read_i, core_write_i, core_addr_i, core_wdata_i,
        input  core_rdata_o, core_stall_o,
        output host_req_i, host_we_i, host_addr_i, host_wdata_i,
        input  host_gnt_o, host_rdata_o, host_valid_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive denied host cycles; flags the last denial before a forced grant.
// Flag is registered-state based (no combinational path from clr_i); no backpressure.
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic thresh_o
);

    localparam logic [ARB_WAIT_W-1:0] SAT_C = ARB_WAIT_W'(MAX_WAIT);
    localparam logic [ARB_WAIT_W-1:0] THR_C = ARB_WAIT_W'(MAX_WAIT - 1);

    logic [ARB_WAIT_W-1:0] cnt_q;
    logic [ARB_WAIT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != SAT_C) begin
            cnt_d = cnt_q + ARB_WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign thresh_o = (cnt_q == THR_C);

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Core-priority arbiter for the data RAM with starvation-forced host cycles; DMEM_ARB_PERF_CNT_EN adds a forced-cycle counter.
// Core path zero latency; host read data/valid one cycle after grant; host held off by withholding host_gnt_o, core by core_stall_o.
module dmem_bus_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH    = DMEM_ADDR_W,
    parameter int DATA_WIDTH    = DMEM_DATA_W,
    parameter int HOST_MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
`ifdef DMEM_ARB_PERF_CNT_EN
    input  logic        stall_count_clr_i,
    output logic [15:0] stall_count_o,
`endif
    dmem_bus_arbiter_if.slave bus
);

    arb_state_e            st_q;
    arb_state_e            st_d;
    arb_owner_e            owner;
    logic                  core_act;
    logic                  host_gnt;
    logic                  wait_thresh;
    logic                  host_valid_q;
    logic [DATA_WIDTH-1:0] host_rdata_q;

    assign core_act = bus.core_read_i | bus.core_write_i;

    always_comb begin
        owner = OWN_NONE;
        if (st_q == ST_FORCE) begin
            owner = OWN_HOST;
        end else if (core_act) begin
            owner = OWN_CORE;
        end else if (bus.host_req_i) begin
            owner = OWN_HOST;
        end
    end

    assign host_gnt = bus.host_req_i & (owner == OWN_HOST);

    // A forced cycle with no host request still owns the bus, so nothing reaches the RAM.
    always_comb begin
        bus.mem_read_o  = 1'b0;
        bus.mem_write_o = 1'b0;
        bus.mem_addr_o  = {ADDR_WIDTH{1'b0}};
        bus.mem_wdata_o = {DATA_WIDTH{1'b0}};
        case (owner)
            OWN_CORE: begin
                bus.mem_read_o  = bus.core_read_i;
                bus.mem_write_o = bus.core_write_i;
                bus.mem_addr_o  = bus.core_addr_i;
                bus.mem_wdata_o = bus.core_wdata_i;
            end
            OWN_HOST: begin
                bus.mem_read_o  = host_gnt & ~bus.host_we_i;
                bus.mem_write_o = host_gnt &  bus.host_we_i;
                bus.mem_addr_o  = bus.host_addr_i;
                bus.mem_wdata_o = bus.host_wdata_i;
            end
            default: ;
        endcase
    end

    arb_wait_counter #(
        .MAX_WAIT (HOST_MAX_WAIT)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (host_gnt | ~bus.host_req_i),
        .thresh_o (wait_thresh)
    );

    always_comb begin
        st_d = st_q;
        if (st_q == ST_FORCE) begin
            st_d = ST_CORE;
        end else if (bus.host_req_i && !host_gnt && wait_thresh) begin
            st_d = ST_FORCE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q         <= ST_CORE;
            host_valid_q <= 1'b0;
            host_rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            st_q         <= st_d;
            host_valid_q <= host_gnt;
            if (host_gnt && !bus.host_we_i) begin
                host_rdata_q <= bus.mem_rdata_i;
            end
        end
    end

    assign bus.core_stall_o = (st_q == ST_FORCE);
    assign bus.core_rdata_o = bus.mem_rdata_i;
    assign bus.host_gnt_o   = host_gnt;
    assign bus.host_valid_o = host_valid_q;
    assign bus.host_rdata_o = host_rdata_q;

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall_count_clr_i) begin
            stall_cnt_q <= 16'h0000;
        end else if (st_q == ST_FORCE && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed and randomized bench for dmem_bus_arbiter with a small RAM and a transaction-level reference model.
module tb_dmem_bus_arbiter;

    localparam int HMW = 8;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:15];

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [15:0] stall_count;
    logic        stall_count_clr;
`endif

    dmem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_bus_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .HOST_MAX_WAIT (HMW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
`ifdef DMEM_ARB_PERF_CNT_EN
        .stall_count_clr_i (stall_count_clr),
        .stall_count_o     (stall_count),
`endif
        .bus               (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench RAM: cleared while reset is low, combinational read.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (bus.mem_write_o) begin
            mem[bus.mem_addr_o[9:2]] <= bus.mem_wdata_o;
        end
    end
    assign bus.mem_rdata_i = mem[bus.mem_addr_o[9:2]];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.core_read_i  = r;
        bus.core_write_i = w;
        bus.core_addr_i  = a;
        bus.core_wdata_i = d;
    endtask

    task automatic set_host(input logic q, input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.host_req_i   = q;
        bus.host_we_i    = we;
        bus.host_addr_i  = a;
        bus.host_wdata_i = d;
    endtask

    // Random-phase model state
    int          denied;
    int          n_forced;
    bit          force_next;
    bit          forced;
    bit          gnt_e;
    bit          prev_valid;
    logic [31:0] exp_rd;
    bit          cur_r, cur_w, h_pend, h_we;
    int          cur_a, h_a;
    logic [31:0] cur_d, h_d;
    int          r;

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b0;
        set_core(0, 0, 0, 0);
        set_host(0, 0, 0, 0);
`ifdef DMEM_ARB_PERF_CNT_EN
        stall_count_clr = 1'b0;
`endif
        #3;
        chk1 ("rst_valid",   bus.host_valid_o, 1'b0);
        chk32("rst_rdata",   bus.host_rdata_o, 32'h0);
        chk1 ("rst_stall",   bus.core_stall_o, 1'b0);
        chk1 ("rst_gnt",     bus.host_gnt_o,   1'b0);
        chk1 ("idle_mrd",    bus.mem_read_o,   1'b0);
        chk1 ("idle_mwr",    bus.mem_write_o,  1'b0);
        chk32("idle_maddr",  bus.mem_addr_o,   32'h0);
        chk32("idle_mwdata", bus.mem_wdata_o,  32'h0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b1;
        tick();

        // Host write preload 0x10, then host read with idle core
        set_host(1, 1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk1 ("hw_gnt",  bus.host_gnt_o,  1'b1);
        chk1 ("hw_mwr",  bus.mem_write_o, 1'b1);
        chk1 ("hw_stall", bus.core_stall_o, 1'b0);
        tick();
        set_host(1, 0, 32'h10, 32'h0);
        @(negedge clk);
        chk1 ("hw_valid", bus.host_valid_o, 1'b1);
        chk32("hw_rdata_kept", bus.host_rdata_o, 32'h0);
        chk1 ("hr_gnt",  bus.host_gnt_o,  1'b1);
        chk1 ("hr_mrd",  bus.mem_read_o,  1'b1);
        chk32("hr_maddr", bus.mem_addr_o, 32'h10);
        tick();
        set_host(0, 0, 0, 0);
        @(negedge clk);
        chk1 ("hr_valid", bus.host_valid_o, 1'b1);
        chk32("hr_rdata", bus.host_rdata_o, 32'hDEADBEEF);
        chk1 ("hr_stall", bus.core_stall_o, 1'b0);
        tick();
        @(negedge clk);
        chk1 ("hr_valid_once", bus.host_valid_o, 1'b0);
        tick();

        // Core priority on a same-address write collision
        set_core(0, 1, 32'h20, 32'h11);
        set_host(1, 1, 32'h20, 32'h22);
        @(negedge clk);
        chk1 ("pri_gnt",    bus.host_gnt_o,  1'b0);
        chk1 ("pri_mwr",    bus.mem_write_o, 1'b1);
        chk32("pri_mwdata", bus.mem_wdata_o, 32'h11);
        tick();
        set_core(0, 0, 0, 0);
        @(negedge clk);
        chk32("pri_mem_core", mem[8], 32'h11);
        chk1 ("pri_gnt2",     bus.host_gnt_o, 1'b1);
        chk32("pri_mwdata2",  bus.mem_wdata_o, 32'h22);
        tick();
        set_host(0, 0, 0, 0);
        @(negedge clk);
        chk1 ("pri_valid",    bus.host_valid_o, 1'b1);
        chk32("pri_mem_host", mem[8], 32'h22);
        tick();

        // Starvation: busy core, host held
        set_core(1, 0, 32'h40, 32'h0);
        set_host(1, 0, 32'h10, 32'h0);
        for (int k = 0; k < HMW; k++) begin
            @(negedge clk);
            chk1("starve_gnt",   bus.host_gnt_o,   1'b0);
            chk1("starve_stall", bus.core_stall_o, 1'b0);
            tick();
        end
        @(negedge clk);
        chk1 ("force_gnt",   bus.host_gnt_o,   1'b1);
        chk1 ("force_stall", bus.core_stall_o, 1'b1);
        chk32("force_maddr", bus.mem_addr_o,   32'h10);
        tick();
        set_host(0, 0, 0, 0);
        @(negedge clk);
        chk1 ("after_stall", bus.core_stall_o, 1'b0);
        chk32("after_maddr", bus.mem_addr_o,   32'h40);
        chk1 ("after_valid", bus.host_valid_o, 1'b1);
        chk32("after_rdata", bus.host_rdata_o, 32'hDEADBEEF);
        tick();
        set_core(0, 0, 0, 0);

        // Back-to-back host writes
        for (int i = 0; i < 4; i++) begin
            set_host(1, 1, 32'(i * 4), 32'hA0 + 32'(i));
            @(negedge clk);
            chk1("b2b_gnt",   bus.host_gnt_o,   1'b1);
            chk1("b2b_valid", bus.host_valid_o, i > 0);
            tick();
        end
        set_host(0, 0, 0, 0);
        @(negedge clk);
        chk1("b2b_valid_last", bus.host_valid_o, 1'b1);
        for (int i = 0; i < 4; i++) chk32("b2b_mem", mem[i], 32'hA0 + 32'(i));
        tick();

        // Reset in the valid cycle of a host read
        set_host(1, 0, 32'h10, 32'h0);
        @(negedge clk);
        chk1("mid_gnt", bus.host_gnt_o, 1'b1);
        tick();
        set_host(0, 0, 0, 0);
        chk1("mid_valid_pre", bus.host_valid_o, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk1 ("mid_valid_rst", bus.host_valid_o, 1'b0);
        chk32("mid_rdata_rst", bus.host_rdata_o, 32'h0);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

        // After reset: fresh counter and ST_CORE
        set_core(1, 0, 32'h40, 32'h0);
        set_host(1, 0, 32'h10, 32'h0);
        for (int k = 0; k < HMW; k++) begin
            @(negedge clk);
            chk1("prst_stall", bus.core_stall_o, 1'b0);
            chk1("prst_gnt",   bus.host_gnt_o,   1'b0);
            tick();
        end
        @(negedge clk);
        chk1("prst_force", bus.core_stall_o, 1'b1);
        tick();
        set_core(0, 0, 0, 0);
        set_host(0, 0, 0, 0);
`ifdef DMEM_ARB_PERF_CNT_EN
        stall_count_clr = 1'b1;
`endif
        @(negedge clk);
        chk1 ("prst_valid", bus.host_valid_o, 1'b1);
        chk32("prst_rdata", bus.host_rdata_o, 32'h0);
`ifdef DMEM_ARB_PERF_CNT_EN
        chk32("perf_one", {16'h0, stall_count}, 32'd1);
`endif
        tick();
`ifdef DMEM_ARB_PERF_CNT_EN
        stall_count_clr = 1'b0;
`endif

        // Randomized traffic against the transaction model
        denied = 0; n_forced = 0; force_next = 0; prev_valid = 0; exp_rd = 32'h0;
        cur_r = 0; cur_w = 0; cur_a = 0; cur_d = 0;
        h_pend = 0; h_we = 0; h_a = 0; h_d = 0;
        for (int c = 0; c < 400; c++) begin
            forced = force_next;
            gnt_e  = h_pend && (forced || !(cur_r || cur_w));
            @(negedge clk);
            chk1 ("rnd_gnt",   bus.host_gnt_o,   gnt_e);
            chk1 ("rnd_stall", bus.core_stall_o, forced);
            chk1 ("rnd_valid", bus.host_valid_o, prev_valid);
            chk32("rnd_hrdata", bus.host_rdata_o, exp_rd);
            chk1 ("rnd_mwr",   bus.mem_write_o, gnt_e ? h_we : (!forced && cur_w));
            if (!forced && cur_r) chk32("rnd_core_rdata", bus.core_rdata_o, ref_mem[cur_a]);
            prev_valid = gnt_e;
            if (gnt_e && !h_we) exp_rd = ref_mem[h_a];
            if (gnt_e && h_we) ref_mem[h_a] = h_d;
            else if (!gnt_e && !forced && cur_w) ref_mem[cur_a] = cur_d;
            if (forced) n_forced++;
            if (h_pend && !gnt_e) denied++; else denied = 0;
            force_next = !forced && h_pend && !gnt_e && (denied == HMW);
            tick();
            if (!forced) begin
                r = int'($urandom_range(0, 19));
                cur_r = (r < 9);
                cur_w = (r >= 9 && r < 17);
                cur_a = int'($urandom_range(0, 15));
                cur_d = $urandom;
            end
            if (!h_pend || gnt_e) begin
                h_pend = ($urandom_range(0, 1) == 1);
                h_we   = ($urandom_range(0, 1) == 1);
                h_a    = int'($urandom_range(0, 15));
                h_d    = $urandom;
            end
            set_core(cur_r, cur_w, 32'(cur_a * 4), cur_d);
            set_host(h_pend, h_we, 32'(h_a * 4), h_d);
        end
        set_core(0, 0, 0, 0);
        set_host(0, 0, 0, 0);
        tick();
        @(negedge clk);
        for (int i = 0; i < 16; i++) chk32("rnd_mem", mem[i], ref_mem[i]);
`ifdef DMEM_ARB_PERF_CNT_EN
        chk32("perf_cnt", {16'h0, stall_count}, 32'(n_forced));
        tick();
        stall_count_clr = 1'b1;
        tick();
        stall_count_clr = 1'b0;
        @(negedge clk);
        chk32("perf_clr", {16'h0, stall_count}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Shares the single-ported data memory between the pipeline MEM stage (core port) and an external host port used for debug, program-data loading and DMA.
- The core has priority. The host is served in cycles where the core makes no access.
- A starvation counter forces one host cycle and stalls the pipeline for that cycle.
- Sits between the EX/MEM register and the GPIO address decoder on the RAM side, i.e. in front of Data_Memory.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- HOST_MAX_WAIT, 8, number of consecutive denied host-request cycles before a forced grant. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_read_i  in  1  MEM-stage RAM read request.
- core_write_i  in  1  MEM-stage RAM write request.
- core_addr_i  in  ADDR_WIDTH  core address.
- core_wdata_i  in  DATA_WIDTH  core write data.
- core_rdata_o  out  DATA_WIDTH  core read data, combinational pass of mem_rdata_i.
- core_stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- host_req_i  in  1  host request; held until granted.
- host_we_i  in  1  1 = write, 0 = read.
- host_addr_i  in  ADDR_WIDTH  host address.
- host_wdata_i  in  DATA_WIDTH  host write data.
- host_gnt_o  out  1  host owns the memory this cycle.
- host_rdata_o  out  DATA_WIDTH  registered host read data.
- host_valid_o  out  1  one-cycle completion pulse.
- mem_read_o  out  1  to Data_Memory Mem_Read_i.
- mem_write_o  out  1  to Data_Memory Mem_Write_i.
- mem_addr_o  out  ADDR_WIDTH  to Data_Memory Address_i.
- mem_wdata_o  out  DATA_WIDTH  to Data_Memory Write_Data_i.
- mem_rdata_i  in  DATA_WIDTH  from Data_Memory Read_Data_o (combinational read).

Behaviour:
- State register st ∈ {ST_CORE, ST_FORCE}.
- wait_cnt is 8 bits.
- Reset (reset=0, asynchronous): st=ST_CORE, wait_cnt=0, host_rdata_o=0, host_valid_o=0.
- With no requests, all combinational outputs are 0.
- Owner selection, combinational, evaluated each cycle:
  - st=ST_FORCE: host owns the bus; core_stall_o=1.
  - else core_read_i|core_write_i: core owns the bus; core_stall_o=0.
  - else host_req_i: host owns the bus opportunistically; core_stall_o=0.
  - else: no owner; mem_read_o=mem_write_o=0.
- Core owner: mem_* = core_* directly; zero added latency; write commits at the rising edge.
- host_gnt_o = host_req_i & (host owns the bus).
- Host owner:
  - mem_read_o=host_gnt_o&~host_we_i.
  - mem_write_o=host_gnt_o&host_we_i.
  - mem_addr_o=host_addr_i; mem_wdata_o=host_wdata_i.
- Host handshake:
  - Request is consumed at the edge where host_gnt_o=1.
  - At that edge, on a read, host_rdata_o <= mem_rdata_i.
  - host_valid_o=1 in the following cycle only, for reads and writes. host_rdata_o is unchanged on writes.
  - Host may present the next request in the valid cycle.
- wait_cnt:
  - Cleared on any edge with host_gnt_o=1 or host_req_i=0.
  - Otherwise increments, saturating at HOST_MAX_WAIT.
- Transitions:
  - ST_CORE→ST_FORCE at an edge where host_req_i=1, host_gnt_o=0 and wait_cnt==HOST_MAX_WAIT-1, i.e. the HOST_MAX_WAIT-th consecutive denial.
  - ST_FORCE→ST_CORE always after exactly one cycle.
- Forced cycle:
  - The core access presented is not performed and is held by the stall; it re-executes next cycle.
  - If host_req_i dropped (protocol violation), the stall still occurs, no memory access is made and no valid pulse is issued.
- Simultaneous core write and host write to the same address: only the owner writes; no merging.
- Reset mid-transfer: a pending valid pulse is discarded; the host must re-request.
- With HOST_MAX_WAIT=1, a continuously busy core alternates one core cycle with one forced host cycle.

Optional Feature:
- Macro DMEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds output stall_count_o [15:0].
  - Counts ST_FORCE cycles, saturating at 16'hFFFF.
  - Cleared by reset.
  - Adds input stall_count_clr_i; synchronous clear, with priority over increment in the same cycle.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package dmem_arb_pkg:
  - State encoding ST_CORE=1'b0, ST_FORCE=1'b1.
  - Default widths DMEM_ADDR_W=32, DMEM_DATA_W=32.
  - Counter width ARB_WAIT_W=8.
- One natural sub-module: arb_wait_counter. It holds the saturating starvation counter and outputs a threshold flag.
- Owner mux and FSM stay in the top module.

Test Plan:
- Host read, idle core: preload mem[0x10]=0xDEADBEEF; host_req read 0x10 → host_gnt_o=1 same cycle; next cycle host_valid_o=1, host_rdata_o=0xDEADBEEF; core_stall_o stays 0.
- Core priority: core_write 0x20←0x11 in the same cycle as host write 0x20←0x22 → mem[0x20]=0x11; host granted the next idle cycle, after which mem[0x20]=0x22.
- Starvation, HOST_MAX_WAIT=8: core accesses every cycle, host_req held → 8 denied cycles; in cycle 9 host_gnt_o=1 and core_stall_o=1; core access repeats in cycle 10; wait_cnt=0 afterwards.
- Back-to-back host: four host writes 0x0,0x4,0x8,0xC with the core idle → one grant per cycle each followed by a valid pulse; memory holds all four values.
- Reset mid-operation: assert reset in the cycle after a host read grant → host_valid_o=0 and host_rdata_o=0 immediately (asynchronous); st=ST_CORE after release.
- With DMEM_ARB_PERF_CNT_EN: 3 forced stalls → stall_count_o=3; pulse stall_count_clr_i → 0.
